shift_right_seq: RTL and testbench

- Multi-cycle right shifter, the companion of the combinational left shifter in the ALU shift path.
- Shifts operand `a` right by `b` positions, one bit per clock, behind a start/busy/done handshake.
- Supports logical (zero-fill) and arithmetic (sign-fill) modes.
- Feeds the ALU result mux and is shared with the shift-unit benches, using the same `bus` width convention.

---
 rtl/shift_right_seq.sv | 128 ++++++++++++
 tb/tb_shift_right_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (logical/arithmetic), one bit per clock, start/busy/done handshake.
// Optional rotate-right mode is elaborated only when SHIFT_ROTATE_EN is defined.
module shift_right_seq #(
   parameter int bus = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [bus-1:0] a,
   input  logic [bus-1:0] b,
   input  logic           arith,
`ifdef SHIFT_ROTATE_EN
   input  logic           rot,
`endif
   output logic [bus-1:0] y,
   output logic           busy,
   output logic           done
);

   localparam int CW = $clog2(bus + 1);
   localparam logic [bus:0]   BUS_EXT = (bus + 1)'(bus);
   localparam logic [CW-1:0]  BUS_CNT = CW'(bus);
`ifdef SHIFT_ROTATE_EN
   localparam logic [bus-1:0] BUS_MOD = bus'(bus);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [bus-1:0] sreg_q, sreg_d;
   logic [bus-1:0] y_q, y_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           fill_q, fill_d;
   logic [CW-1:0]  amt;
   logic           in_bit;
`ifdef SHIFT_ROTATE_EN
   logic           rot_q, rot_d;
`endif

   // Shift amounts beyond the width would only repeat fill bits, so clamp them.
   always_comb begin
      amt = ({1'b0, b} > BUS_EXT) ? BUS_CNT : b[CW-1:0];
`ifdef SHIFT_ROTATE_EN
      if (rot) begin
         amt = CW'(b % BUS_MOD);
      end
`endif
   end

   always_comb begin
      in_bit = fill_q;
`ifdef SHIFT_ROTATE_EN
      if (rot_q) begin
         in_bit = sreg_q[0];
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
`ifdef SHIFT_ROTATE_EN
      rot_d   = rot_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               sreg_d  = a;
               fill_d  = arith & a[bus-1];
               cnt_d   = amt;
`ifdef SHIFT_ROTATE_EN
               rot_d   = rot;
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               sreg_d = {in_bit, sreg_q[bus-1:1]};
               cnt_d  = cnt_q - 1'b1;
            end else begin
               y_d     = sreg_q;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         fill_q  <= 1'b0;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end

   assign y    = y_q;
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed table, hand sequences, randomized ops vs model.
module tb_shift_right_seq;

   localparam int BUS = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [BUS-1:0] a, b;
   logic           arith;
   logic           rot;
   logic [BUS-1:0] y;
   logic           busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   shift_right_seq #(.bus(BUS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .arith (arith),
`ifdef SHIFT_ROTATE_EN
      .rot   (rot),
`endif
      .y     (y),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BUS-1:0] a;
      logic [BUS-1:0] b;
      logic           arith;
      logic           rot;
      logic [BUS-1:0] exp_y;
      int             exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference result straight from the operation's definition.
   function automatic logic [BUS-1:0] model_y(input logic [BUS-1:0] ma, input logic [BUS-1:0] mb,
                                              input logic march, input logic mrot);
      int n;
      logic [2*BUS-1:0] dbl;
      logic [BUS-1:0] r;
      if (mrot) begin
         n   = int'(mb) % BUS;
         dbl = {ma, ma} >> n;
         r   = dbl[BUS-1:0];
      end else begin
         n = (int'(mb) > BUS) ? BUS : int'(mb);
         if (march) r = $signed(ma) >>> n;
         else       r = ma >> n;
      end
      return r;
   endfunction

   function automatic int model_lat(input logic [BUS-1:0] mb, input logic mrot);
      if (mrot) return (int'(mb) % BUS) + 1;
      return ((int'(mb) > BUS) ? BUS : int'(mb)) + 1;
   endfunction

   // Edges counted after the accepting edge until done is seen.
   task automatic do_op(input logic [BUS-1:0] ia, input logic [BUS-1:0] ib, input logic iarith,
                        input logic irot, output logic [BUS-1:0] oy, output int lat, output int bcyc);
      @(negedge clk);
      a = ia; b = ib; arith = iarith; rot = irot; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~ia; b = ~ib; arith = ~iarith;
      lat  = 0;
      bcyc = busy ? 1 : 0;
      while (!done && lat < 30) begin
         @(posedge clk); #1;
         lat++;
         if (busy) bcyc++;
      end
      oy = y;
      if (lat >= 30) check("done_timeout", 32'(lat), 32'(model_lat(ib, irot)));
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
      check("y_hold", 32'(y), 32'(oy));
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      logic [BUS-1:0] ry;
      int lat, bcyc;
      do_op(v.a, v.b, v.arith, v.rot, ry, lat, bcyc);
      $display("op %s a=%b b=%b arith=%0d rot=%0d -> y=%b lat=%0d busy=%0d", tag, v.a, v.b,
               v.arith, v.rot, ry, lat, bcyc);
      check({tag, "_y"}, 32'(ry), 32'(v.exp_y));
      check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
      check({tag, "_busy"}, 32'(bcyc), 32'(v.exp_lat + 1));
   endtask

   initial begin
      vec_t table_v[$];
      vec_t v;
      logic [BUS-1:0] ry;
      int lat, seen;

      table_v.push_back('{4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0111, 2});
      table_v.push_back('{4'b1000, 4'b0010, 1'b1, 1'b0, 4'b1110, 3});
      table_v.push_back('{4'b1000, 4'b0010, 1'b0, 1'b0, 4'b0010, 3});
      table_v.push_back('{4'b1010, 4'b0000, 1'b0, 1'b0, 4'b1010, 1});
      table_v.push_back('{4'b1111, 4'b0101, 1'b0, 1'b0, 4'b0000, 5});
      table_v.push_back('{4'b1000, 4'b1111, 1'b1, 1'b0, 4'b1111, 5});
      table_v.push_back('{4'b0110, 4'b0100, 1'b0, 1'b0, 4'b0000, 5});
      table_v.push_back('{4'b1011, 4'b0100, 1'b1, 1'b0, 4'b1111, 5});
`ifdef SHIFT_ROTATE_EN
      table_v.push_back('{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b1000, 2});
      table_v.push_back('{4'b0001, 4'b0101, 1'b1, 1'b1, 4'b1000, 2});
      table_v.push_back('{4'b1001, 4'b0010, 1'b1, 1'b1, 4'b0110, 3});
`endif

      rst = 1'b1; start = 1'b0; a = '0; b = '0; arith = 1'b0; rot = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_y", 32'(y), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < table_v.size(); i++) run_vec($sformatf("vec%0d", i), table_v[i]);

      // Asynchronous reset while idle with a nonzero result held.
      do_op(4'b0101, 4'b0000, 1'b0, 1'b0, ry, lat, seen);
      check("pre_reset_y", 32'(y), 32'b0101);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      $display("op async_reset_idle y=%b busy=%0d done=%0d", y, busy, done);
      check("async_rst_y", 32'(y), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Start held high while busy with a different operand must be ignored.
      @(negedge clk);
      a = 4'b1000; b = 4'b0010; arith = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      a = 4'b0001; b = 4'b0000; arith = 1'b0;
      lat = 0;
      repeat (2) begin @(posedge clk); #1; lat++; end
      start = 1'b0;
      while (!done && lat < 30) begin @(posedge clk); #1; lat++; end
      $display("op start_while_busy y=%b lat=%0d", y, lat);
      check("busy_ignore_y", 32'(y), 32'b1110);
      check("busy_ignore_lat", 32'(lat), 32'd3);
      @(posedge clk); #1;
      check("busy_ignore_idle", 32'(busy), 32'd0);

      // Abort mid-shift: no done pulse, no resumption.
      @(negedge clk);
      a = 4'b1111; b = 4'b0100; arith = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_y", 32'(y), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (8) begin @(posedge clk); #1; if (done || busy) seen++; end
      $display("op abort_mid_shift y=%b activity_after=%0d", y, seen);
      check("abort_no_done", 32'(seen), 32'd0);
      check("abort_y_after", 32'(y), 32'd0);
      v = '{4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0111, 2};
      run_vec("after_abort", v);

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         v.a     = BUS'($urandom);
         v.b     = BUS'($urandom);
         v.arith = 1'($urandom);
`ifdef SHIFT_ROTATE_EN
         v.rot   = 1'($urandom);
`else
         v.rot   = 1'b0;
`endif
         v.exp_y   = model_y(v.a, v.b, v.arith, v.rot);
         v.exp_lat = model_lat(v.b, v.rot);
         run_vec($sformatf("rnd%0d", i), v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
